digit_entry: RTL
================

DIGIT_ENTRY -- requirements
Module: digit_entry

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 50_000_000, idle cycles in ENTRY before auto-clear (used only with DIGIT_ENTRY_TIMEOUT_EN).
REQ-002 The block SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port key_valid, input, 1, one-cycle strobe qualifying key_code.
REQ-005 The block SHALL have port key_code, input, 4, 0x0-0x9 digit, 0xA enter, 0xB clear, 0xC-0xF ignored.
REQ-006 The block SHALL have port centenas, output, 4, hundreds BCD digit.
REQ-007 The block SHALL have port decenas, output, 4, tens BCD digit.
REQ-008 The block SHALL have port unidades, output, 4, units BCD digit.
REQ-009 The block SHALL have port cargar, output, 1, one-cycle load strobe to the downstream accumulator.
REQ-010 The block SHALL have port digit_count, output, 2, number of digits entered (0-3).
REQ-011 The block SHALL have port entry_full, output, 1, high while digit_count==3.

Function
REQ-012 The block SHALL implement a registered FSM with states IDLE (count 0), ENTRY (count 1-3) and COMMIT.
REQ-013 The block SHALL sample key_code only when key_valid=1, and SHALL ignore key_valid in COMMIT.
REQ-014 In IDLE or ENTRY with count<3, a digit key SHALL shift left (centenas<=decenas, decenas<=unidades, unidades<=key_code), increment count and go to ENTRY, all on the next edge.
REQ-015 A digit key at count==3 SHALL be dropped, with all digit outputs and count unchanged.
REQ-016 An enter key in ENTRY SHALL move to COMMIT, with cargar=1 during exactly the COMMIT cycle (one-cycle latency from the sampling edge) and digits stable.
REQ-017 An enter key in IDLE SHALL be ignored, with no cargar pulse.
REQ-018 From COMMIT the FSM SHALL return to IDLE unconditionally after one cycle, zeroing all digits and count on that edge.
REQ-019 A clear key in IDLE or ENTRY SHALL zero digits and count and go to IDLE, with no cargar pulse.
REQ-020 Codes 0xC-0xF SHALL have no effect.
REQ-021 cargar SHALL never be high for two consecutive cycles.
REQ-022 Digit outputs SHALL never hold a value above 9.

Reset
REQ-023 With reset=1 at an edge, the block SHALL set state IDLE, centenas=decenas=unidades=0, digit_count=0, entry_full=0, cargar=0 and the timeout counter to 0.
REQ-024 Reset SHALL take priority over all keys, including during COMMIT: cargar is 0 in the cycle after the reset edge.

Configuration
REQ-025 With macro DIGIT_ENTRY_TIMEOUT_EN defined, an idle counter SHALL run in ENTRY and restart on every accepted key_valid.
REQ-026 With DIGIT_ENTRY_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES-1 SHALL act as a clear key, with no cargar pulse.
REQ-027 With DIGIT_ENTRY_TIMEOUT_EN undefined, no counter SHALL be synthesized and ENTRY SHALL persist indefinitely.

Structure
REQ-028 Package digit_entry_pkg SHALL hold the key-code constants (KEY_ENTER=4'hA, KEY_CLEAR=4'hB) and the state enum typedef.
REQ-029 The timeout counter SHALL be sub-module entry_timer (inputs clk, reset, run, restart; output expired), instantiated only under DIGIT_ENTRY_TIMEOUT_EN.

Verification
REQ-030 A bench SHALL cover: keys 1,2,3 then A -> cargar=1 for one cycle with 1/2/3; next cycle all 0, count 0.
REQ-031 A bench SHALL cover: keys 7 then A -> cargar with 0/0/7; A in IDLE -> no cargar.
REQ-032 A bench SHALL cover: keys 9,8,7,6 -> 9/8/7, entry_full=1, 6 dropped.
REQ-033 A bench SHALL cover: keys 4,5,B then A -> all 0, IDLE, no cargar.
REQ-034 A bench SHALL cover: keys 2,A with reset asserted in the COMMIT cycle -> cargar 0 the following cycle, all outputs 0.
REQ-035 A bench SHALL cover: with the macro defined and TIMEOUT_CYCLES=8, key 5 then 8 idle cycles -> auto-clear, no cargar; with a key every 7 cycles -> no clear.

Source files
------------

// File: rtl/digit_entry_pkg.sv
// ---------------------------------------------------------------------------
// digit_entry_pkg
// Shared definitions for the keypad digit-entry block:
//   - key codes for the two control keys (enter, clear)
//   - the digit-entry FSM state type
//   - a helper that classifies a key code as a decimal digit
// ---------------------------------------------------------------------------
package digit_entry_pkg;

    localparam logic [3:0] KEY_ENTER = 4'hA;
    localparam logic [3:0] KEY_CLEAR = 4'hB;
    localparam logic [3:0] MAX_DIGIT = 4'h9;
    localparam logic [1:0] MAX_COUNT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ENTRY  = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    // Codes 0x0-0x9 are digits; everything above is a control or unused code.
    function automatic logic is_digit(input logic [3:0] code);
        return (code <= MAX_DIGIT);
    endfunction

endpackage

// File: rtl/entry_timer.sv
// ---------------------------------------------------------------------------
// entry_timer
// Idle-cycle counter used to auto-clear a half-typed number.
// Only compiled when DIGIT_ENTRY_TIMEOUT_EN is defined; without the macro
// this file contributes no module and no counter exists in the design.
//
// Parameters:
//   TIMEOUT_CYCLES - number of idle cycles before expiry
// Ports:
//   clk     - clock, rising edge
//   reset   - synchronous active-high reset
//   run     - count while high, held at zero while low
//   restart - zero the counter this edge (a key was accepted)
//   expired - high while running and the count has reached TIMEOUT_CYCLES-1
// ---------------------------------------------------------------------------
`ifdef DIGIT_ENTRY_TIMEOUT_EN
module entry_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic restart,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // The counter saturates at LAST so expiry stays asserted until the FSM
    // leaves ENTRY, which drops run and zeroes the count.
    always_comb begin
        count_d = count_q;
        if (!run || restart) begin
            count_d = '0;
        end else if (count_q != LAST) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = run && (count_q == LAST);

endmodule
`endif

// File: rtl/digit_entry.sv
// ---------------------------------------------------------------------------
// digit_entry
// Collects up to three BCD digits from a keypad strobe interface and hands
// them to a downstream accumulator with a one-cycle load strobe.
//
// Optional feature macro: DIGIT_ENTRY_TIMEOUT_EN
//   When defined, an idle timer clears a partial entry after TIMEOUT_CYCLES
//   cycles without an accepted key. When undefined, entry persists forever.
//
// Parameters:
//   TIMEOUT_CYCLES - idle cycles in ENTRY before auto-clear (timeout build only)
// Ports:
//   clk         - sole clock, rising edge
//   reset       - synchronous active-high reset
//   key_valid   - one-cycle strobe qualifying key_code
//   key_code    - 0-9 digit, 0xA enter, 0xB clear, 0xC-0xF ignored
//   centenas    - hundreds digit
//   decenas     - tens digit
//   unidades    - units digit
//   cargar      - one-cycle load strobe, high during the COMMIT cycle
//   digit_count - digits entered so far (0-3)
//   entry_full  - high while three digits are held
// ---------------------------------------------------------------------------
module digit_entry
    import digit_entry_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [3:0] centenas,
    output logic [3:0] decenas,
    output logic [3:0] unidades,
    output logic       cargar,
    output logic [1:0] digit_count,
    output logic       entry_full
);

    state_e     state_q,    state_d;
    logic [3:0] centenas_q, centenas_d;
    logic [3:0] decenas_q,  decenas_d;
    logic [3:0] unidades_q, unidades_d;
    logic [1:0] count_q,    count_d;
    logic       keyAccepted;
    logic       timeoutHit;

`ifdef DIGIT_ENTRY_TIMEOUT_EN
    entry_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_entry_timer (
        .clk     (clk),
        .reset   (reset),
        .run     (state_q == ST_ENTRY),
        .restart (keyAccepted),
        .expired (timeoutHit)
    );
`else
    assign timeoutHit = 1'b0;

    // The parameter only matters in the timeout build; this empty block keeps
    // it referenced so both builds elaborate the same interface.
    if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
    end
`endif

    // Next-state logic. Digits only ever come from key codes 0-9 or zero, so
    // the outputs can never hold a non-BCD value. A key in the same cycle as
    // a timeout wins, since the user is evidently still typing.
    always_comb begin
        state_d     = state_q;
        centenas_d  = centenas_q;
        decenas_d   = decenas_q;
        unidades_d  = unidades_q;
        count_d     = count_q;
        keyAccepted = 1'b0;

        case (state_q)
            ST_IDLE, ST_ENTRY: begin
                if (key_valid && is_digit(key_code)) begin
                    keyAccepted = 1'b1;
                    if (count_q != MAX_COUNT) begin
                        centenas_d = decenas_q;
                        decenas_d  = unidades_q;
                        unidades_d = key_code;
                        count_d    = count_q + 2'd1;
                        state_d    = ST_ENTRY;
                    end
                end else if (key_valid && (key_code == KEY_ENTER)) begin
                    keyAccepted = 1'b1;
                    if (state_q == ST_ENTRY) begin
                        state_d = ST_COMMIT;
                    end
                end else if ((key_valid && (key_code == KEY_CLEAR)) ||
                             (timeoutHit && (state_q == ST_ENTRY))) begin
                    keyAccepted = key_valid;
                    centenas_d  = 4'd0;
                    decenas_d   = 4'd0;
                    unidades_d  = 4'd0;
                    count_d     = 2'd0;
                    state_d     = ST_IDLE;
                end
            end

            // The load strobe lasts exactly this one cycle; keys are ignored.
            ST_COMMIT: begin
                centenas_d = 4'd0;
                decenas_d  = 4'd0;
                unidades_d = 4'd0;
                count_d    = 2'd0;
                state_d    = ST_IDLE;
            end

            default: begin
                centenas_d = 4'd0;
                decenas_d  = 4'd0;
                unidades_d = 4'd0;
                count_d    = 2'd0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            centenas_q <= 4'd0;
            decenas_q  <= 4'd0;
            unidades_q <= 4'd0;
            count_q    <= 2'd0;
        end else begin
            state_q    <= state_d;
            centenas_q <= centenas_d;
            decenas_q  <= decenas_d;
            unidades_q <= unidades_d;
            count_q    <= count_d;
        end
    end

    // COMMIT always exits after one cycle, so cargar cannot stay high twice.
    assign cargar      = (state_q == ST_COMMIT);
    assign centenas    = centenas_q;
    assign decenas     = decenas_q;
    assign unidades    = unidades_q;
    assign digit_count = count_q;
    assign entry_full  = (count_q == MAX_COUNT);

endmodule
